sll: RTL and testbench

- Immediate-formatting unit for the single-cycle/pipelined MIPS datapath (P4 cpu).
- Takes the 16-bit instruction immediate and produces a 32-bit operand:
  - either the immediate placed in the upper half (LUI-style shift left by 16),
  - or the immediate zero-extended into the lower half.
- Output is registered on the system clock; feeds the ALU B-operand mux / GRF write-data mux.

---
 rtl/sll.sv | 47 ++++
 tb/tb_sll.sv | 113 +++++++++++
 2 files changed

// File: rtl/sll.sv
// Immediate formatter for the MIPS datapath.
// Turns the 16-bit instruction immediate into a 32-bit operand, either
// placed in the upper half (LUI-style) or zero-extended into the lower
// half. The result is registered, so it appears one clock after the
// imm/sllOp pair is sampled.
module sll #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IMM_W-1:0] imm,
  input  logic             sllOp,
  output logic [OUT_W-1:0] sllImm
);

  // Zero-extended immediate. Every upper bit is zero, so bit IMM_W-1 is
  // never replicated and the value is never sign-extended.
  logic [OUT_W-1:0] zeroExt;
  // Immediate moved into the upper half with a zero lower half.
  logic [OUT_W-1:0] shifted;
  // Value the register captures on the next rising edge.
  logic [OUT_W-1:0] nextImm;

  assign zeroExt = OUT_W'(imm);
  assign shifted = zeroExt << SHAMT;

  // Select the format. A conditional operator is used rather than
  // if/else so that an unknown sllOp is not silently resolved to one
  // branch in simulation: the differing bits go unknown instead.
  always_comb begin
    nextImm = '0;
    nextImm = sllOp ? shifted : zeroExt;
  end

  // Output register: loads every cycle, and reset clears it
  // synchronously, taking priority over the data inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sllImm <= '0;
    end else begin
      sllImm <= nextImm;
    end
  end

endmodule

// File: tb/tb_sll.sv
// Directed testbench for the sll immediate formatter.
// Each step drives inputs on the falling edge, lets one rising edge pass
// and then compares the registered output to a hand-computed value.
module tb_sll;

  logic        clk;
  logic        reset;
  logic [15:0] imm;
  logic        sllOp;
  logic [31:0] sllImm;

  int errorCount;
  int checkCount;

  sll dut (
    .clk    (clk),
    .reset  (reset),
    .imm    (imm),
    .sllOp  (sllOp),
    .sllImm (sllImm)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one input set on the falling edge, then wait until just after
  // the following rising edge so the output can be sampled safely.
  task automatic applyStimulus(input logic rstV, input logic [15:0] immV,
                               input logic opV);
    @(negedge clk);
    reset = rstV;
    imm   = immV;
    sllOp = opV;
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Directed sequence following the test plan.
  initial begin
    errorCount = 0;
    checkCount = 0;
    reset = 1'b1;
    imm   = 16'h1234;
    sllOp = 1'b1;

    // Reset held for two cycles with live inputs.
    applyStimulus(1'b1, 16'h1234, 1'b1);
    checkOutput("reset0", sllImm, 32'h0000_0000);
    applyStimulus(1'b1, 16'h1234, 1'b1);
    checkOutput("reset1", sllImm, 32'h0000_0000);
    applyStimulus(1'b0, 16'h1234, 1'b1);
    checkOutput("postReset", sllImm, 32'h1234_0000);

    // Zero-extend with bit 15 set must not sign-extend.
    applyStimulus(1'b0, 16'h8001, 1'b0);
    checkOutput("zext8001", sllImm, 32'h0000_8001);

    // All-ones boundary in both formats.
    applyStimulus(1'b0, 16'hFFFF, 1'b1);
    checkOutput("shlFFFF", sllImm, 32'hFFFF_0000);
    applyStimulus(1'b0, 16'hFFFF, 1'b0);
    checkOutput("zextFFFF", sllImm, 32'h0000_FFFF);
    #4;
    checkOutput("stableMid", sllImm, 32'h0000_FFFF);

    // Back-to-back stream with simultaneous imm/sllOp changes.
    applyStimulus(1'b0, 16'h0001, 1'b1);
    checkOutput("stream0", sllImm, 32'h0001_0000);
    applyStimulus(1'b0, 16'hABCD, 1'b0);
    checkOutput("stream1", sllImm, 32'h0000_ABCD);
    applyStimulus(1'b0, 16'h7FFF, 1'b1);
    checkOutput("stream2", sllImm, 32'h7FFF_0000);

    // Mid-stream reset discards the in-flight value.
    applyStimulus(1'b0, 16'h0001, 1'b1);
    checkOutput("midA", sllImm, 32'h0001_0000);
    applyStimulus(1'b1, 16'hABCD, 1'b0);
    checkOutput("midReset", sllImm, 32'h0000_0000);
    applyStimulus(1'b0, 16'hABCD, 1'b0);
    checkOutput("midResume", sllImm, 32'h0000_ABCD);
    applyStimulus(1'b0, 16'h7FFF, 1'b1);
    checkOutput("midNext", sllImm, 32'h7FFF_0000);

    // Zero immediate gives zero regardless of sllOp.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0000, i[0]);
      checkOutput("zeroImm", sllImm, 32'h0000_0000);
    end

    // Non-symmetric pattern to expose any swapped or shifted bits.
    applyStimulus(1'b0, 16'h5A3C, 1'b1);
    checkOutput("shl5A3C", sllImm, 32'h5A3C_0000);
    applyStimulus(1'b0, 16'h5A3C, 1'b0);
    checkOutput("zext5A3C", sllImm, 32'h0000_5A3C);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
